// File: rtl/lsu_bus_if.sv
// Word-wide req/ack data bus between the load/store unit (master) and memory (slave).
interface lsu_bus_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_err, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_err, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_bridge.sv
// Load/store unit: turns single-cycle core memory accesses into stalled req/ack bus
// transactions with natural-alignment checks, lane steering and load extension.
module lsu_bus_bridge #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] aluresult,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        fault,
    lsu_bus_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic access_ok(input logic [2:0] f3, input logic st, input logic [1:0] a);
        case (f3)
            3'b000:  return 1'b1;
            3'b001:  return ~a[0];
            3'b010:  return (a == 2'b00);
            3'b100:  return ~st;
            3'b101:  return ~st & ~a[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  return 4'b0001 << a;
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'b000:  return {4{wd[7:0]}};
            3'b001:  return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h000000, sh[7:0]};
            3'b101:  return {16'h0000, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic [31:0]    read_data_q, read_data_d;
    logic           fault_q, fault_d;
    logic           bus_req_q, bus_req_d;
    logic           bus_we_q, bus_we_d;
    logic [31:0]    bus_addr_q, bus_addr_d;
    logic [31:0]    bus_wdata_q, bus_wdata_d;
    logic [3:0]     bus_be_q, bus_be_d;
    logic [2:0]     funct3_q, funct3_d;
    logic [1:0]     off_q, off_d;
    logic           access_s, legal_s, start_s, reject_s;

    assign access_s  = mem_read | memwrite;
    assign legal_s   = access_ok(funct3, memwrite, aluresult[1:0]);
    assign start_s   = (state_q == IDLE) & access_s & legal_s;
    assign reject_s  = (state_q == IDLE) & access_s & ~legal_s;
    assign cnt_inc_s = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        fault_d     = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        case (state_q)
            IDLE: begin
                cnt_d = {TO_W{1'b0}};
                if (start_s) begin
                    state_d     = BUS;
                    bus_req_d   = 1'b1;
                    bus_we_d    = memwrite;
                    bus_addr_d  = {aluresult[31:2], 2'b00};
                    bus_be_d    = memwrite ? store_be(funct3, aluresult[1:0]) : 4'b1111;
                    bus_wdata_d = store_lanes(funct3, write_data);
                    funct3_d    = funct3;
                    off_d       = aluresult[1:0];
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                cnt_d = cnt_inc_s;
                // Error beats a simultaneous ack; the timeout only fires when nothing answered.
                if (bus.bus_err || (!bus.bus_ack && cnt_inc_s == TO_W'(TIMEOUT))) begin
                    state_d     = DONE;
                    bus_req_d   = 1'b0;
                    read_data_d = 32'h0000_0000;
                    fault_d     = 1'b1;
                end else if (bus.bus_ack) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        read_data_d = load_extend(funct3_q, off_q, bus.bus_rdata);
                    end else begin
                        read_data_d = read_data_q;
                    end
                end else begin
                    state_d = BUS;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = {TO_W{1'b0}};
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
                cnt_d     = {TO_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= {TO_W{1'b0}};
            read_data_q <= 32'h0000_0000;
            fault_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wdata_q <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            fault_q     <= fault_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
        end
    end

    // Accept/reject must reach the core in the detect cycle, so those terms bypass the flops.
    assign stall     = start_s | (state_q == BUS);
    assign fault     = fault_q | reject_s;
    assign read_data = reject_s ? 32'h0000_0000 : read_data_q;

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_be    = bus_be_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed self-checking bench for lsu_bus_bridge; the bench plays both core and memory.
module tb_lsu_bus_bridge;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] aluresult;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        fault;

    lsu_bus_if bus_if ();

    lsu_bus_bridge #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .memwrite   (memwrite),
        .funct3     (funct3),
        .aluresult  (aluresult),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .fault      (fault),
        .bus        (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Results captured by run_access.
    int          req_cnt;
    int          stall_cnt;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [31:0] done_rd;
    logic        done_fault;
    logic        idle_req;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One full access; resp_at = BUS cycle (1-based) answered, 0 = never answered.
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int resp_at, input logic use_err, input logic [31:0] rdata);
        bit done;
        req_cnt = 0;
        done    = 1'b0;
        @(negedge clk);
        mem_read   = ld;
        memwrite   = st;
        funct3     = f3;
        aluresult  = addr;
        write_data = wd;
        #1;
        stall_cnt = int'(stall);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            bus_if.bus_ack = 1'b0;
            bus_if.bus_err = 1'b0;
            #1;
            if (!bus_if.bus_req) begin
                done = 1'b1;
            end else begin
                req_cnt++;
                stall_cnt += int'(stall);
                cap_addr  = bus_if.bus_addr;
                cap_wdata = bus_if.bus_wdata;
                cap_be    = bus_if.bus_be;
                cap_we    = bus_if.bus_we;
                if (req_cnt == resp_at) begin
                    bus_if.bus_rdata = rdata;
                    if (use_err) bus_if.bus_err = 1'b1;
                    else         bus_if.bus_ack = 1'b1;
                end
            end
        end
        if (!done) check_eq("bus_bound", 32'd0, 32'd1);
        // DONE cycle: core inputs deliberately left stale.
        done_rd    = read_data;
        done_fault = fault;
        stall_cnt += int'(stall);
        @(negedge clk);
        mem_read = 1'b0;
        memwrite = 1'b0;
        #1;
        idle_req = bus_if.bus_req;
    endtask

    task automatic reject_access(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        @(negedge clk);
        mem_read  = 1'b1;
        memwrite  = 1'b0;
        funct3    = f3;
        aluresult = addr;
        #1;
        check_eq({tag, "_stall"}, {31'd0, stall}, 32'd0);
        check_eq({tag, "_fault"}, {31'd0, fault}, 32'd1);
        check_eq({tag, "_rd"}, read_data, 32'h0000_0000);
        @(negedge clk);
        mem_read = 1'b0;
        #1;
        check_eq({tag, "_req"}, {31'd0, bus_if.bus_req}, 32'd0);
        check_eq({tag, "_fault_gone"}, {31'd0, fault}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        mem_read = 1'b0;
        memwrite = 1'b0;
        funct3 = 3'b000;
        aluresult = 32'h0;
        write_data = 32'h0;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_err = 1'b0;
        bus_if.bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_req", {31'd0, bus_if.bus_req}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_fault", {31'd0, fault}, 32'd0);
        check_eq("rst_rd", read_data, 32'h0);
        check_eq("rst_addr", bus_if.bus_addr, 32'h0);
        check_eq("rst_be", {28'd0, bus_if.bus_be}, 32'd0);
        reset = 1'b0;

        // lw, ack on first BUS cycle
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, 1'b0, 32'hDEADBEEF);
        check_eq("lw_addr", cap_addr, 32'h100);
        check_eq("lw_be", {28'd0, cap_be}, 32'hF);
        check_eq("lw_we", {31'd0, cap_we}, 32'd0);
        check_eq("lw_req_cycles", req_cnt, 32'd1);
        check_eq("lw_stall_cycles", stall_cnt, 32'd2);
        check_eq("lw_rd", done_rd, 32'hDEADBEEF);
        check_eq("lw_fault", {31'd0, done_fault}, 32'd0);
        check_eq("lw_no_retrigger", {31'd0, idle_req}, 32'd0);

        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 1'b0, 32'h80FF1234);
        check_eq("lb_rd", done_rd, 32'hFFFFFF80);
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 1'b0, 32'h80FF1234);
        check_eq("lbu_rd", done_rd, 32'h00000080);
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 1'b0, 32'h80FF1234);
        check_eq("lh_rd", done_rd, 32'hFFFF80FF);
        check_eq("lh_addr", cap_addr, 32'h100);
        run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1, 1'b0, 32'h80FF1234);
        check_eq("lhu_rd", done_rd, 32'h000080FF);

        run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 1, 1'b0, 32'h0);
        check_eq("sb_addr", cap_addr, 32'h200);
        check_eq("sb_be", {28'd0, cap_be}, 32'h2);
        check_eq("sb_wdata", cap_wdata, 32'hA5A5A5A5);
        check_eq("sb_we", {31'd0, cap_we}, 32'd1);
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 1, 1'b0, 32'h0);
        check_eq("sh_be", {28'd0, cap_be}, 32'hC);
        check_eq("sh_wdata", cap_wdata, 32'h12341234);

        reject_access("lw_misaligned", 3'b010, 32'h102);
        reject_access("load_f3_011", 3'b011, 32'h100);

        // Wait states: ack on the 3rd BUS cycle
        run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 3, 1'b0, 32'h13579BDF);
        check_eq("wait_stall_cycles", stall_cnt, 32'd4);
        check_eq("wait_rd", done_rd, 32'h13579BDF);

        run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 0, 1'b0, 32'h0);
        check_eq("to_req_cycles", req_cnt, 32'd16);
        check_eq("to_fault", {31'd0, done_fault}, 32'd1);
        check_eq("to_rd", done_rd, 32'h0);

        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 1'b1, 32'hCAFEF00D);
        check_eq("err_req_cycles", req_cnt, 32'd3);
        check_eq("err_fault", {31'd0, done_fault}, 32'd1);
        check_eq("err_rd", done_rd, 32'h0);

        // Reset during the 2nd BUS cycle
        @(negedge clk);
        mem_read  = 1'b1;
        funct3    = 3'b010;
        aluresult = 32'h500;
        @(negedge clk);
        #1;
        check_eq("mid_req_bus1", {31'd0, bus_if.bus_req}, 32'd1);
        @(negedge clk);
        reset    = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_req", {31'd0, bus_if.bus_req}, 32'd0);
        check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
        check_eq("mid_rst_fault", {31'd0, fault}, 32'd0);

        run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1, 1'b0, 32'h0BADC0DE);
        check_eq("post_rst_req_cycles", req_cnt, 32'd1);
        check_eq("post_rst_rd", done_rd, 32'h0BADC0DE);
        check_eq("post_rst_fault", {31'd0, done_fault}, 32'd0);

        run_access(1'b1, 1'b1, 3'b010, 32'h108, 32'h11223344, 1, 1'b0, 32'h0);
        check_eq("both_we", {31'd0, cap_we}, 32'd1);
        check_eq("both_wdata", cap_wdata, 32'h11223344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
